// File: rtl/reg_file_bp_pkg.sv
// Shared types for the bypassing register file.
`include "reg_file_bp_defs.vh"

package reg_file_bp_pkg;

    typedef enum logic {
        ST_CLEAR = `RF_ST_CLEAR,
        ST_RUN   = `RF_ST_RUN
    } rf_state_e;

    function automatic int reg_num(input int addr_width);
        return `RF_REG_NUM(addr_width);
    endfunction

endpackage

// File: rtl/reg_file_bp_defs.vh
`ifndef REG_FILE_BP_DEFS_VH
`define REG_FILE_BP_DEFS_VH

`define RF_ST_CLEAR 1'b0
`define RF_ST_RUN   1'b1
`define RF_REG_NUM(aw) (1 << (aw))

`endif

// File: rtl/rf_byte_merge.sv
// Byte-strobed merge of new data over old data.
// Latency: combinational. Backpressure: none.
// Bytes with a clear strobe keep the old value.
module rf_byte_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_dat,
    input  logic [DATA_WIDTH-1:0]   new_dat,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged_dat
);

    always_comb begin
        merged_dat = old_dat;
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (strb[i]) begin
                merged_dat[8*i +: 8] = new_dat[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/reg_file_bp.sv
// Multi-port register file with byte strobes, optional write-to-read bypass and post-reset clear.
// Latency: reads combinational, writes visible next cycle (same cycle with BYPASS=1).
// Backpressure: ready low for REG_NUM cycles after reset; writes then are dropped and flagged.
`include "reg_file_bp_defs.vh"

module reg_file_bp
    import reg_file_bp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic                         wen,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic                         ready,
    output logic                         wr_drop
);

    localparam int REG_NUM = `RF_REG_NUM(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(REG_NUM - 1);

    rf_state_e             state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [DATA_WIDTH-1:0] rf [REG_NUM];
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  wr_zero_addr;
    logic                  wr_commit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (wen) begin
                        wr_drop <= 1'b1;
                    end
                    if (clr_ptr == CLR_LAST) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    rf_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_wr_merge (
        .old_dat    (rf[waddr]),
        .new_dat    (wdata),
        .strb       (wstrb),
        .merged_dat (wr_merged)
    );

    assign wr_zero_addr = (ZERO_REG != 0) && (waddr == '0);
    assign wr_commit    = (state == ST_RUN) && wen && !wr_zero_addr;

    // Data array is zeroed by the clear walk, not by reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_CLEAR) begin
                rf[clr_ptr] <= '0;
            end else if (wr_commit) begin
                rf[waddr] <= wr_merged;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] old_dat;
        logic [DATA_WIDTH-1:0] fwd_dat;
        logic                  is_zero;
        logic                  hit;

        assign ra      = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign old_dat = rf[ra];

        rf_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_merge (
            .old_dat    (old_dat),
            .new_dat    (wdata),
            .strb       (wstrb),
            .merged_dat (fwd_dat)
        );

        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign hit     = (BYPASS != 0) && wen && (waddr == ra);

        assign rdata[k*DATA_WIDTH +: DATA_WIDTH] =
            (!ready || is_zero) ? '0 : (hit ? fwd_dat : old_dat);
    end

endmodule

// File: tb/tb_reg_file_bp.sv
// Bench for reg_file_bp: a bypassing 2-port build and a non-bypassing 4-port build sharing writes.
module tb_reg_file_bp;

    logic        clk;
    logic        rst_n;
    logic [4:0]  waddr;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        ready;
    logic        wr_drop;
    logic [19:0] alt_raddr;
    logic [127:0] alt_rdata;
    logic        alt_ready;
    logic        alt_wr_drop;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [32];
    bit          model_ready;

    reg_file_bp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wen(wen), .wstrb(wstrb), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .ready(ready), .wr_drop(wr_drop)
    );

    reg_file_bp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(4), .BYPASS(0), .ZERO_REG(1)) u_alt (
        .clk(clk), .rst_n(rst_n), .waddr(waddr), .wen(wen), .wstrb(wstrb), .wdata(wdata),
        .raddr(alt_raddr), .rdata(alt_rdata), .ready(alt_ready), .wr_drop(alt_wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge_ref(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit bypass);
        if (!model_ready || a == 5'd0) return 32'h0;
        if (bypass && wen && waddr == a) return merge_ref(mem[a], wdata, wstrb);
        return mem[a];
    endfunction

    // One clock: commit the current write into the model, then land on the next negedge.
    task automatic tick();
        @(posedge clk);
        if (model_ready && wen && waddr != 5'd0) mem[waddr] = merge_ref(mem[waddr], wdata, wstrb);
        @(negedge clk);
    endtask

    task automatic count_to_ready(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (ready) break;
        end
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    endtask

    typedef struct {
        logic        wen;
        logic [4:0]  wa;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] ea0;
        logic [31:0] ea1;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int n;
        tbl[0] = '{1'b1, 5'd5, 4'hF, 32'hFFFFFFFF, 5'd5, 5'd6, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0};
        tbl[1] = '{1'b1, 5'd5, 4'h5, 32'h12345678, 5'd5, 5'd5, 32'hFF34FF78, 32'hFF34FF78, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[2] = '{1'b0, 5'd5, 4'hF, 32'h0,        5'd5, 5'd0, 32'hFF34FF78, 32'h0,        32'hFF34FF78, 32'h0};
        tbl[3] = '{1'b1, 5'd7, 4'hF, 32'hAAAAAAAA, 5'd5, 5'd7, 32'hFF34FF78, 32'hAAAAAAAA, 32'hFF34FF78, 32'h0};
        tbl[4] = '{1'b1, 5'd7, 4'h3, 32'h11223344, 5'd7, 5'd7, 32'hAAAA3344, 32'hAAAA3344, 32'hAAAAAAAA, 32'hAAAAAAAA};
        tbl[5] = '{1'b1, 5'd0, 4'hF, 32'hDEADBEEF, 5'd0, 5'd7, 32'h0,        32'hAAAA3344, 32'h0,        32'hAAAA3344};
        tbl[6] = '{1'b0, 5'd0, 4'hF, 32'hDEADBEEF, 5'd0, 5'd7, 32'h0,        32'hAAAA3344, 32'h0,        32'hAAAA3344};
        tbl[7] = '{1'b1, 5'd9, 4'h0, 32'hFFFFFFFF, 5'd9, 5'd9, 32'h0,        32'h0,        32'h0,        32'h0};
        tbl[8] = '{1'b0, 5'd9, 4'h0, 32'h0,        5'd9, 5'd5, 32'h0,        32'hFF34FF78, 32'h0,        32'hFF34FF78};

        rst_n = 1'b0; wen = 1'b0; waddr = '0; wstrb = '0; wdata = '0;
        raddr = {5'd6, 5'd5}; alt_raddr = '0;
        model_ready = 1'b0;
        model_clear();

        // Reset held for two cycles
        @(negedge clk); @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_wr_drop", {31'h0, wr_drop}, 32'h0);
        chk("rst_rdata0", rdata[31:0], 32'h0);
        rst_n = 1'b1;
        count_to_ready(n);
        chk("clear_len", 32'(n), 32'd32);
        chk("alt_ready", {31'h0, alt_ready}, 32'h1);
        model_ready = 1'b1;

        for (int i = 0; i < 32; i++) begin
            raddr = {5'(i), 5'(i)};
            #1;
            chk("clear_zero", rdata[31:0] | rdata[63:32], 32'h0);
            @(negedge clk);
        end

        for (int i = 0; i < 9; i++) begin
            wen = tbl[i].wen; waddr = tbl[i].wa; wstrb = tbl[i].strb; wdata = tbl[i].wd;
            raddr = {tbl[i].ra1, tbl[i].ra0};
            alt_raddr = {10'h0, tbl[i].ra1, tbl[i].ra0};
            #1;
            chk("tbl_rd0", rdata[31:0], tbl[i].e0);
            chk("tbl_rd1", rdata[63:32], tbl[i].e1);
            chk("tbl_alt0", alt_rdata[31:0], tbl[i].ea0);
            chk("tbl_alt1", alt_rdata[63:32], tbl[i].ea1);
            tick();
        end
        wen = 1'b0;

        // Four distinct concurrent reads on the 4-port build
        for (int i = 0; i < 4; i++) begin
            wen = 1'b1; waddr = 5'(10 + i); wstrb = 4'hF; wdata = 32'hA0000000 + 32'(i);
            tick();
        end
        wen = 1'b0;
        alt_raddr = {5'd13, 5'd12, 5'd11, 5'd10};
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("four_port", alt_rdata[32*k +: 32], 32'hA0000000 + 32'(k));
        end
        @(negedge clk);

        for (int c = 0; c < 400; c++) begin
            wen = ($urandom_range(0, 2) != 0);
            waddr = 5'($urandom_range(0, 7));
            wstrb = 4'($urandom);
            wdata = $urandom;
            raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            alt_raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 31)), 5'($urandom_range(0, 7))};
            #1;
            for (int k = 0; k < 2; k++)
                chk("rnd_bp", rdata[32*k +: 32], exp_read(raddr[5*k +: 5], 1'b1));
            for (int k = 0; k < 4; k++)
                chk("rnd_nobp", alt_rdata[32*k +: 32], exp_read(alt_raddr[5*k +: 5], 1'b0));
            tick();
        end
        wen = 1'b0;
        chk("run_no_drop", {31'h0, wr_drop}, 32'h0);

        // Write during clear is dropped and flagged
        rst_n = 1'b0; model_ready = 1'b0; model_clear();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        wen = 1'b1; waddr = 5'd3; wstrb = 4'hF; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        wen = 1'b0;
        chk("drop_set", {31'h0, wr_drop}, 32'h1);
        chk("drop_ready_low", {31'h0, ready}, 32'h0);
        count_to_ready(n);
        chk("drop_clear_rest", 32'(n), 32'd21);
        chk("drop_sticky", {31'h0, wr_drop}, 32'h1);
        raddr = {5'd3, 5'd3}; alt_raddr = {15'h0, 5'd3};
        #1;
        chk("drop_rf3", rdata[31:0], 32'h0);
        chk("drop_alt_rf3", alt_rdata[31:0], 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("drop_cleared", {31'h0, wr_drop}, 32'h0);

        // Reset in the middle of the clear walk restarts it
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_ready", {31'h0, ready}, 32'h0);
        rst_n = 1'b1;
        count_to_ready(n);
        chk("mid_clear_len", 32'(n), 32'd32);
        model_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raddr = {5'(31 - i), 5'(10 + i)};
            #1;
            chk("mid_zero0", rdata[31:0], exp_read(5'(10 + i), 1'b1));
            chk("mid_zero1", rdata[63:32], 32'h0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
